// File: rtl/sea_iter_core_if.sv
// Request/response bundle for the iterative Feistel block cipher core.
// master drives a request (in_*) and the out_ready acceptance; slave is the core side.
// Ports: in_valid/in_ready/in_mode/in_data/in_key, out_valid/out_ready/out_data.
interface sea_iter_core_if #(
   parameter int N = 96
);
   logic         in_valid;
   logic         in_ready;
   logic         in_mode;
   logic [N-1:0] in_data;
   logic [N-1:0] in_key;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] out_data;

   modport master (
      output in_valid, in_mode, in_data, in_key, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_mode, in_data, in_key, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/sea_iter_core.sv
// Iterative Feistel block cipher (encrypt/decrypt), one round or key step per cycle.
// Latency: accept edge to out_valid is NR+1 cycles (encrypt) or 2*NR+1 cycles (decrypt, incl. key expansion).
// Backpressure: one request in flight; in_ready only in IDLE, result held in DONE until out_ready.
// Ports: clk, rst (sync, active-high), io (sea_iter_core_if.slave), busy (state is not IDLE).
// Optional: define SEA_KEY_CACHE_EN to cache the last decrypt key and its fully expanded key state,
// so a repeated decrypt key skips the key expansion phase.
module sea_iter_core #(
   parameter int N  = 96,
   parameter int B  = 8,
   parameter int NR = 16
) (
   input  logic               clk,
   input  logic               rst,
   sea_iter_core_if.slave     io,
   output logic               busy
);
   localparam int H  = N / 2;
   localparam int NB = H / B;
   localparam logic [7:0] NR_C = 8'(NR);

   typedef enum logic [1:0] {IDLE, KEXP, ROUND, DONE} state_t;

   state_t         state_q, state_d;
   logic [7:0]     cnt_q, cnt_d;
   logic           mode_q, mode_d;
   logic [H-1:0]   l_q, l_d, r_q, r_d;
   logic [H-1:0]   kl_q, kl_d, kr_q, kr_d;

`ifdef SEA_KEY_CACHE_EN
   logic [N-1:0]   ck_key_q, ck_key_d;
   logic [H-1:0]   ck_kl_q, ck_kl_d, ck_kr_q, ck_kr_d;
   logic           ck_vld_q, ck_vld_d;
   logic           ck_hit;
`endif

   // 3-bit S-box applied per bit column of each 3-word group
   function automatic logic [2:0] sbox3(input logic [2:0] v);
      case (v)
         3'd0:    return 3'd0;
         3'd1:    return 3'd5;
         3'd2:    return 3'd6;
         3'd3:    return 3'd7;
         3'd4:    return 3'd4;
         3'd5:    return 3'd3;
         3'd6:    return 3'd1;
         default: return 3'd2;
      endcase
   endfunction

   // Round function: word-wise add, bit-sliced S-box over word triples, rotate words up by one
   function automatic logic [H-1:0] f_fn(input logic [H-1:0] x, input logic [H-1:0] c);
      logic [H-1:0] a;
      logic [H-1:0] s;
      logic [H-1:0] o;
      logic [2:0]   v;
      a = '0;
      s = '0;
      o = '0;
      for (int w = 0; w < NB; w++) begin
         a[w*B +: B] = x[w*B +: B] + c[w*B +: B];
      end
      for (int g = 0; g < NB/3; g++) begin
         for (int j = 0; j < B; j++) begin
            // bit j of word 3g is the S-box input lsb, word 3g+2 the msb
            v = sbox3({a[(3*g+2)*B+j], a[(3*g+1)*B+j], a[(3*g)*B+j]});
            s[(3*g)*B+j]   = v[0];
            s[(3*g+1)*B+j] = v[1];
            s[(3*g+2)*B+j] = v[2];
         end
      end
      for (int w = 0; w < NB; w++) begin
         o[((w+1)%NB)*B +: B] = s[w*B +: B];
      end
      return o;
   endfunction

   // Data path F: encrypt feeds R with round key KR, decrypt feeds L with KL
   // (in the decrypt direction KL of key state i equals the round key K_i).
   logic [H-1:0] fd_x, fd_c, fd;
   // Key path F: forward steps use KR; backward steps during decrypt rounds use KL.
   logic [H-1:0] fk_x, fk;

   assign fd_x = mode_q ? l_q  : r_q;
   assign fd_c = mode_q ? kl_q : kr_q;
   assign fd   = f_fn(fd_x, fd_c);
   assign fk_x = (state_q == ROUND && mode_q) ? kl_q : kr_q;
   assign fk   = f_fn(fk_x, {{(H-8){1'b0}}, cnt_q});

`ifdef SEA_KEY_CACHE_EN
   assign ck_hit = ck_vld_q && (io.in_key == ck_key_q);
`endif

   assign io.in_ready  = (state_q == IDLE);
   assign io.out_valid = (state_q == DONE);
   assign io.out_data  = (state_q == DONE) ? {l_q, r_q} : '0;
   assign busy         = (state_q != IDLE);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      l_d     = l_q;
      r_d     = r_q;
      kl_d    = kl_q;
      kr_d    = kr_q;
`ifdef SEA_KEY_CACHE_EN
      ck_key_d = ck_key_q;
      ck_kl_d  = ck_kl_q;
      ck_kr_d  = ck_kr_q;
      ck_vld_d = ck_vld_q;
`endif
      case (state_q)
         IDLE: begin
            if (io.in_valid) begin
               l_d    = io.in_data[N-1:H];
               r_d    = io.in_data[H-1:0];
               kl_d   = io.in_key[N-1:H];
               kr_d   = io.in_key[H-1:0];
               mode_d = io.in_mode;
               cnt_d  = 8'd1;
               if (!io.in_mode) begin
                  state_d = ROUND;
               end else begin
`ifdef SEA_KEY_CACHE_EN
                  if (ck_hit) begin
                     state_d = ROUND;
                     cnt_d   = NR_C;
                     kl_d    = ck_kl_q;
                     kr_d    = ck_kr_q;
                  end else begin
                     // Entry becomes valid only once this expansion completes;
                     // an aborted expansion leaves the cache empty.
                     state_d  = KEXP;
                     ck_key_d = io.in_key;
                     ck_vld_d = 1'b0;
                  end
`else
                  state_d = KEXP;
`endif
               end
            end
         end
         KEXP: begin
            kl_d = kr_q;
            kr_d = kl_q ^ fk;
            if (cnt_q == NR_C) begin
               state_d = ROUND;
`ifdef SEA_KEY_CACHE_EN
               ck_kl_d  = kr_q;
               ck_kr_d  = kl_q ^ fk;
               ck_vld_d = 1'b1;
`endif
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         ROUND: begin
            if (!mode_q) begin
               l_d  = r_q;
               r_d  = l_q ^ fd;
               kl_d = kr_q;
               kr_d = kl_q ^ fk;
               if (cnt_q == NR_C) state_d = DONE;
               else               cnt_d   = cnt_q + 8'd1;
            end else begin
               r_d  = l_q;
               l_d  = r_q ^ fd;
               kr_d = kl_q;
               kl_d = kr_q ^ fk;
               if (cnt_q == 8'd1) state_d = DONE;
               else               cnt_d   = cnt_q - 8'd1;
            end
         end
         DONE: begin
            if (io.out_ready) state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         mode_q  <= 1'b0;
         l_q     <= '0;
         r_q     <= '0;
         kl_q    <= '0;
         kr_q    <= '0;
`ifdef SEA_KEY_CACHE_EN
         ck_key_q <= '0;
         ck_kl_q  <= '0;
         ck_kr_q  <= '0;
         ck_vld_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         l_q     <= l_d;
         r_q     <= r_d;
         kl_q    <= kl_d;
         kr_q    <= kr_d;
`ifdef SEA_KEY_CACHE_EN
         ck_key_q <= ck_key_d;
         ck_kl_q  <= ck_kl_d;
         ck_kr_q  <= ck_kr_d;
         ck_vld_q <= ck_vld_d;
`endif
      end
   end
endmodule

// File: tb/tb_sea_iter_core.sv
// Bench for sea_iter_core: default core (NR=16) against a behavioural cipher model, plus an NR=1 core.
// Latency is counted in clock edges with the accept edge as edge 1.
// Ports: drives both cores through sea_iter_core_if instances.
module tb_sea_iter_core;
   localparam int N  = 96;
   localparam int B  = 8;
   localparam int H  = N / 2;
   localparam int NB = H / B;
   localparam int NR = 16;
   localparam int SBOX [8] = '{0, 5, 6, 7, 4, 3, 1, 2};

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic busy0, busy1;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   acc_cyc = 0;
   bit   seen = 1'b0;
   logic [N-1:0] exp_q[$];
   int           lat_q[$];
`ifdef SEA_KEY_CACHE_EN
   bit           mc_vld = 1'b0;
   logic [N-1:0] mc_key = '0;
`endif

   sea_iter_core_if #(.N(N)) io0();
   sea_iter_core_if #(.N(N)) io1();

   sea_iter_core #(.N(N), .B(B), .NR(NR)) u_dut0 (.clk(clk), .rst(rst), .io(io0), .busy(busy0));
   sea_iter_core #(.N(N), .B(B), .NR(1))  u_dut1 (.clk(clk), .rst(rst), .io(io1), .busy(busy1));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- behavioural model ----------------
   function automatic logic [H-1:0] f_m(input logic [H-1:0] x, input logic [H-1:0] c);
      logic [B-1:0] w [NB];
      logic [B-1:0] o [NB];
      logic [H-1:0] res;
      int v;
      for (int i = 0; i < NB; i++) w[i] = x[i*B +: B] + c[i*B +: B];
      for (int g = 0; g < NB/3; g++) begin
         for (int j = 0; j < B; j++) begin
            v = SBOX[{w[3*g+2][j], w[3*g+1][j], w[3*g][j]}];
            w[3*g][j]   = v[0];
            w[3*g+1][j] = v[1];
            w[3*g+2][j] = v[2];
         end
      end
      for (int i = 0; i < NB; i++) o[(i+1) % NB] = w[i];
      for (int i = 0; i < NB; i++) res[i*B +: B] = o[i];
      return res;
   endfunction

   // Full cipher: expand all round keys first, then run the Feistel rounds in the requested direction.
   function automatic logic [N-1:0] crypt_m(input logic mode, input logic [N-1:0] d,
                                            input logic [N-1:0] k, input int nr);
      logic [H-1:0] rk [1:255];
      logic [H-1:0] kl, kr, l, r, t;
      kl = k[N-1:H];
      kr = k[H-1:0];
      for (int i = 1; i <= nr; i++) begin
         rk[i] = kr;
         t  = kr;
         kr = kl ^ f_m(kr, H'(i));
         kl = t;
      end
      l = d[N-1:H];
      r = d[H-1:0];
      if (!mode) begin
         for (int i = 1; i <= nr; i++) begin
            t = r;
            r = l ^ f_m(r, rk[i]);
            l = t;
         end
      end else begin
         for (int i = nr; i >= 1; i--) begin
            t = l;
            l = r ^ f_m(l, rk[i]);
            r = t;
         end
      end
      return {l, r};
   endfunction

   function automatic logic [N-1:0] rnd();
      return {$urandom, $urandom, $urandom};
   endfunction

   // ---------------- checkers ----------------
   task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, want);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %b want %b", nm, act, want);
      end
   endtask

   task automatic chki(input string nm, input int act, input int want);
      total++;
      if (act != want) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, want);
      end
   endtask

   // Compare process for the default core: every cycle a result is presented it must match
   // the model's pending expectation, keep in_ready low, and arrive with the modelled latency.
   always @(negedge clk) begin
      if (!rst && io0.out_valid) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious_out: got out_valid=1 data=%h want no result", io0.out_data);
         end else begin
            chk("out_data", io0.out_data, exp_q[0]);
            chk1("in_ready_in_done", io0.in_ready, 1'b0);
            if (!seen) begin
               seen = 1'b1;
               chki("latency", cyc - acc_cyc + 1, lat_q[0]);
            end
            if (io0.out_ready) begin
               void'(exp_q.pop_front());
               void'(lat_q.pop_front());
               seen = 1'b0;
            end
         end
      end
   end

   // ---------------- drivers ----------------
   task automatic do_reset();
      io0.in_valid  = 1'b0;
      io0.out_ready = 1'b0;
      io1.in_valid  = 1'b0;
      io1.out_ready = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      lat_q.delete();
      seen = 1'b0;
`ifdef SEA_KEY_CACHE_EN
      mc_vld = 1'b0;
`endif
   endtask

   // One request on the default core; unrelated in_valid traffic is held up while busy and
   // during the result handshake cycle, none of which may be taken.
   task automatic run_op(input logic mode, input logic [N-1:0] d, input logic [N-1:0] k,
                         input int hold, output logic [N-1:0] got);
      int n;
      int el;
      got = '0;
      el  = mode ? 2*NR + 1 : NR + 1;
`ifdef SEA_KEY_CACHE_EN
      if (mode) begin
         if (mc_vld && mc_key == k) el = NR + 1;
         mc_vld = 1'b1;
         mc_key = k;
      end
`endif
      n = 0;
      while (!io0.in_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
      exp_q.push_back(crypt_m(mode, d, k, NR));
      lat_q.push_back(el);
      io0.in_valid = 1'b1;
      io0.in_mode  = mode;
      io0.in_data  = d;
      io0.in_key   = k;
      @(posedge clk); #1;
      acc_cyc = cyc;
      io0.in_mode = 1'($urandom);
      io0.in_data = rnd();
      io0.in_key  = rnd();
      n = 0;
      while (!io0.out_valid && n < 2*NR + 10) begin
         @(posedge clk); #1; n++;
      end
      if (!io0.out_valid) begin
         total++;
         bad++;
         $display("FAIL result_timeout: got no out_valid within %0d cycles want latency %0d", n, el);
         do_reset();
         return;
      end
      got = io0.out_data;
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         chk1("hold_valid", io0.out_valid, 1'b1);
      end
      io0.out_ready = 1'b1;
      @(posedge clk); #1;
      io0.out_ready = 1'b0;
      io0.in_valid  = 1'b0;
      chk1("idle_after_done", busy0, 1'b0);
      chk1("valid_dropped", io0.out_valid, 1'b0);
   endtask

   // One request on the NR=1 core with literal expectations.
   task automatic run1(input string nm, input logic mode, input logic [N-1:0] d,
                       input logic [N-1:0] k, input logic [N-1:0] want, input int want_lat);
      int lat;
      io1.in_valid = 1'b1;
      io1.in_mode  = mode;
      io1.in_data  = d;
      io1.in_key   = k;
      @(posedge clk); #1;
      io1.in_valid = 1'b0;
      lat = 1;
      while (!io1.out_valid && lat < 10) begin
         @(posedge clk); #1; lat++;
      end
      chki({nm, "_lat"}, lat, want_lat);
      chk({nm, "_data"}, io1.out_data, want);
      io1.out_ready = 1'b1;
      @(posedge clk); #1;
      io1.out_ready = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [N-1:0] p, k, c, back, junk;
      logic [N-1:0] kpool [3];
      logic [N-1:0] a5;
      int n;

      io0.in_valid = 1'b0; io0.in_mode = 1'b0; io0.in_data = '0; io0.in_key = '0; io0.out_ready = 1'b0;
      io1.in_valid = 1'b0; io1.in_mode = 1'b0; io1.in_data = '0; io1.in_key = '0; io1.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // reset state
      chk1("rst_out_valid", io0.out_valid, 1'b0);
      chk("rst_out_data", io0.out_data, '0);
      chk1("rst_in_ready", io0.in_ready, 1'b1);
      chk1("rst_busy", busy0, 1'b0);
      chk1("rst_in_ready_nr1", io1.in_ready, 1'b1);
      chk1("rst_busy_nr1", busy1, 1'b0);

      // model pins: hand-computed values
      chk("model_f_pin", {48'h0, f_m(48'h0, 48'h1)}, {48'h0, 48'h0000_0100_0100});
      a5 = {48'hA5A5_0F0F_1234, 48'h0};
      chk("model_nr1_pin", crypt_m(1'b0, a5, '0, 1), {48'h0, 48'hA5A5_0F0F_1234});
      p = rnd();
      k = rnd();
      chk("model_roundtrip", crypt_m(1'b1, crypt_m(1'b0, p, k, NR), k, NR), p);

      // NR=1 core: zero block, A5 pattern, and the inverse of the A5 result
      run1("nr1_zero", 1'b0, '0, '0, '0, 2);
      run1("nr1_a5", 1'b0, a5, '0, {48'h0, 48'hA5A5_0F0F_1234}, 2);
      run1("nr1_dec", 1'b1, {48'h0, 48'hA5A5_0F0F_1234}, '0, a5, 3);

      // encrypt then decrypt with the same key returns the plaintext
      run_op(1'b0, p, k, 0, c);
      run_op(1'b1, c, k, 0, back);
      chk("roundtrip_plain", back, p);

      // result held for 5 cycles under backpressure
      run_op(1'b0, rnd(), rnd(), 5, junk);

      // repeated decrypt key, then reset, then the same key again
      k = rnd();
      run_op(1'b1, rnd(), k, 0, junk);
      run_op(1'b1, rnd(), k, 1, junk);
      do_reset();
      run_op(1'b1, rnd(), k, 0, junk);

      // reset in the cycle round 8 would execute
      n = 0;
      while (!io0.in_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
      io0.in_valid = 1'b1;
      io0.in_mode  = 1'b0;
      io0.in_data  = rnd();
      io0.in_key   = rnd();
      @(posedge clk); #1;
      io0.in_valid = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
`ifdef SEA_KEY_CACHE_EN
      mc_vld = 1'b0;
`endif
      chk1("abort_out_valid", io0.out_valid, 1'b0);
      chk("abort_out_data", io0.out_data, '0);
      chk1("abort_in_ready", io0.in_ready, 1'b1);
      chk1("abort_busy", busy0, 1'b0);
      repeat (2*NR) @(posedge clk);
      #1;
      chk1("abort_stays_idle", busy0, 1'b0);

      // random traffic with a small key pool so decrypt keys repeat
      for (int i = 0; i < 3; i++) kpool[i] = rnd();
      for (int i = 0; i < 24; i++) begin
         run_op(1'($urandom), rnd(), kpool[$urandom_range(0, 2)], int'($urandom_range(0, 3)), junk);
      end

      repeat (4) @(posedge clk);
      chki("queue_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
